// File: rtl/mac_vec_if.sv
// Handshake and operand bus for the mac_vec multi-lane dot-product engine.
// The master side feeds beats and consumes results; the slave side is the engine.
interface mac_vec_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 24,
  parameter int CNT_WIDTH  = 8
);
  logic                        in_valid;
  logic                        in_ready;
  logic                        signed_mode;
  logic [CNT_WIDTH-1:0]        vec_len;
  logic [LANES*DATA_WIDTH-1:0] a_vec;
  logic [LANES*DATA_WIDTH-1:0] b_vec;
  logic                        out_valid;
  logic                        out_ready;
  logic [ACC_WIDTH-1:0]        acc_out;
  logic                        sat;

  modport master (
    output in_valid, signed_mode, vec_len, a_vec, b_vec, out_ready,
    input  in_ready, out_valid, acc_out, sat
  );

  modport slave (
    input  in_valid, signed_mode, vec_len, a_vec, b_vec, out_ready,
    output in_ready, out_valid, acc_out, sat
  );
endinterface

// File: rtl/mac_vec.sv
// Multi-lane MAC: LANES products per beat, adder-tree reduction, accumulation over vec_len beats.
// Define MAC_VEC_SATURATE_EN to clamp the accumulator to the latched mode's range and report sat.
module mac_vec #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 24,
  parameter int CNT_WIDTH  = 8
) (
  input logic     clk,
  input logic     rst,
  input logic     clr,
  mac_vec_if.slave bus
);
  localparam int PW = 2 * DATA_WIDTH;

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  generate
    if (ACC_WIDTH < PW + $clog2(LANES)) begin : g_width_check
      $error("mac_vec: ACC_WIDTH too small to hold an exact lane sum");
    end
  endgenerate

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] len_q;
  logic                 mode_q;

  logic                 flush;
  logic                 accept;
  logic                 first;
  logic                 cur_mode;
  logic [CNT_WIDTH-1:0] cur_len;
  logic                 last_beat;

  assign flush        = rst | clr;
  assign bus.in_ready = (state == ST_ACCUM) && !flush;
  assign accept       = bus.in_valid && bus.in_ready;
  // Mode and length come straight from the bus on the first beat, from the latches afterwards.
  assign first        = (cnt == '0);
  assign cur_mode     = first ? bus.signed_mode : mode_q;
  assign cur_len      = first ? ((bus.vec_len == '0) ? CNT_WIDTH'(1) : bus.vec_len) : len_q;
  assign last_beat    = ((cnt + CNT_WIDTH'(1)) == cur_len);

  logic [PW-1:0] prod_d [LANES];
  logic [PW-1:0] prod_q [LANES];
  logic          v1, last1, mode1;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_l, b_l;
    logic [PW-1:0]         a_x, b_x;
    assign a_l = bus.a_vec[i*DATA_WIDTH +: DATA_WIDTH];
    assign b_l = bus.b_vec[i*DATA_WIDTH +: DATA_WIDTH];
    assign a_x = cur_mode ? {{DATA_WIDTH{a_l[DATA_WIDTH-1]}}, a_l} : {{DATA_WIDTH{1'b0}}, a_l};
    assign b_x = cur_mode ? {{DATA_WIDTH{b_l[DATA_WIDTH-1]}}, b_l} : {{DATA_WIDTH{1'b0}}, b_l};
    assign prod_d[i] = a_x * b_x;
  end

  logic [ACC_WIDTH-1:0] sum_d;
  logic [ACC_WIDTH-1:0] sum_q;
  logic                 v2, last2, mode2;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mode1) sum_d = sum_d + ACC_WIDTH'($signed(prod_q[i]));
      else       sum_d = sum_d + ACC_WIDTH'(prod_q[i]);
    end
  end

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;
  logic                 clip_d;
  logic                 sat_q;

`ifdef MAC_VEC_SATURATE_EN
  logic [ACC_WIDTH:0] acc_wide;

  // One guard bit exposes overflow; a clamped value keeps accumulating from the rail.
  always_comb begin
    clip_d   = 1'b0;
    acc_wide = mode2 ? ({acc_q[ACC_WIDTH-1], acc_q} + {sum_q[ACC_WIDTH-1], sum_q})
                     : ({1'b0, acc_q} + {1'b0, sum_q});
    acc_d    = acc_wide[ACC_WIDTH-1:0];
    if (mode2) begin
      if (acc_wide[ACC_WIDTH] != acc_wide[ACC_WIDTH-1]) begin
        clip_d = 1'b1;
        acc_d  = acc_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end else if (acc_wide[ACC_WIDTH]) begin
      clip_d = 1'b1;
      acc_d  = '1;
    end
  end
`else
  always_comb begin
    acc_d  = acc_q + sum_q;
    clip_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (flush) begin
      state  <= ST_ACCUM;
      cnt    <= '0;
      len_q  <= '0;
      mode_q <= 1'b0;
      v1     <= 1'b0;
      last1  <= 1'b0;
      mode1  <= 1'b0;
      v2     <= 1'b0;
      last2  <= 1'b0;
      mode2  <= 1'b0;
      sum_q  <= '0;
      acc_q  <= '0;
      sat_q  <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
        last1 <= last_beat;
        mode1 <= cur_mode;
        cnt   <= cnt + CNT_WIDTH'(1);
        if (first) begin
          len_q  <= cur_len;
          mode_q <= cur_mode;
        end
      end

      v2 <= v1;
      if (v1) begin
        sum_q <= sum_d;
        last2 <= last1;
        mode2 <= mode1;
      end

      if (v2) begin
        acc_q <= acc_d;
        sat_q <= sat_q | clip_d;
      end

      case (state)
        ST_ACCUM: if (accept && last_beat) state <= ST_DRAIN;
        ST_DRAIN: if (v2 && last2) state <= ST_OUT;
        ST_OUT: begin
          if (bus.out_ready) begin
            state <= ST_ACCUM;
            acc_q <= '0;
            sat_q <= 1'b0;
            cnt   <= '0;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

  assign bus.out_valid = (state == ST_OUT);
  assign bus.acc_out   = acc_q;
  assign bus.sat       = sat_q;
endmodule

// File: tb/tb_mac_vec.sv
// Scoreboard bench for mac_vec: a 24-bit and an 18-bit accumulator instance share one stimulus stream.
// Expected results are hand-computed constants; MAC_VEC_SATURATE_EN selects the clamped expectations.
module tb_mac_vec;
  typedef struct packed {
    logic [23:0] acc;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        signed_mode = 1'b0;
  logic [7:0]  vec_len = 8'd0;
  logic [31:0] a_vec = '0;
  logic [31:0] b_vec = '0;
  logic        out_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  exp_t q24[$];
  exp_t q18[$];

  mac_vec_if #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(24), .CNT_WIDTH(8)) bus24 ();
  mac_vec_if #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(18), .CNT_WIDTH(8)) bus18 ();

  assign bus24.in_valid    = in_valid;
  assign bus24.signed_mode = signed_mode;
  assign bus24.vec_len     = vec_len;
  assign bus24.a_vec       = a_vec;
  assign bus24.b_vec       = b_vec;
  assign bus24.out_ready   = out_ready;
  assign bus18.in_valid    = in_valid;
  assign bus18.signed_mode = signed_mode;
  assign bus18.vec_len     = vec_len;
  assign bus18.a_vec       = a_vec;
  assign bus18.b_vec       = b_vec;
  assign bus18.out_ready   = out_ready;

  mac_vec #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(24), .CNT_WIDTH(8)) u_dut24 (
    .clk(clk), .rst(rst), .clr(clr), .bus(bus24.slave)
  );
  mac_vec #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(18), .CNT_WIDTH(8)) u_dut18 (
    .clk(clk), .rst(rst), .clr(clr), .bus(bus18.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic pushExp(input logic [23:0] e24, input logic s24, input logic [23:0] e18, input logic s18);
    q24.push_back('{acc: e24, sat: s24});
    q18.push_back('{acc: e18, sat: s18});
  endtask

  // Drive one beat and hold it until the DUT accepts it; returns at posedge+1 after acceptance.
  task automatic applyStimulus(input logic sm, input logic [7:0] len, input logic [31:0] a, input logic [31:0] b);
    logic ok;
    int   waited;
    in_valid    = 1'b1;
    signed_mode = sm;
    vec_len     = len;
    a_vec       = a;
    b_vec       = b;
    ok          = 1'b0;
    waited      = 0;
    while (!ok && waited < 50) begin
      @(negedge clk);
      ok = bus24.in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat_accept_timeout: in_ready stayed 0 for %0d cycles", waited);
    end
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((q24.size() != 0 || q18.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q24.size() != 0 || q18.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL result_timeout: %0d/%0d results still pending", q24.size(), q18.size());
      q24.delete();
      q18.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop one expectation per output handshake of each instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !clr && bus24.out_valid && bus24.out_ready) begin
      if (q24.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL acc24_unexpected: got %0d, expected no result", bus24.acc_out);
      end else begin
        e = q24.pop_front();
        checkOutput("acc24", 32'(bus24.acc_out), 32'(e.acc));
        checkOutput("sat24", 32'(bus24.sat), 32'(e.sat));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && !clr && bus18.out_valid && bus18.out_ready) begin
      if (q18.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL acc18_unexpected: got %0d, expected no result", bus18.acc_out);
      end else begin
        e = q18.pop_front();
        checkOutput("acc18", 32'(bus18.acc_out), 32'(e.acc));
        checkOutput("sat18", 32'(bus18.sat), 32'(e.sat));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int bad;
    int n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(bus24.in_ready), 0);
    checkOutput("rst_out_valid", 32'(bus24.out_valid), 0);
    checkOutput("rst_acc_out", 32'(bus24.acc_out), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_in_ready", 32'(bus24.in_ready), 1);
    @(posedge clk);
    #1;

    // Unsigned two-beat vector, second beat carries changed mode/len that must be ignored.
    out_ready = 1'b0;
    pushExp(24'd260170, 1'b0, 24'd260170, 1'b0);
    applyStimulus(1'b0, 8'd2, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
    applyStimulus(1'b1, 8'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 1) checkOutput("t1_in_ready_after_last", 32'(bus24.in_ready), 0);
      if (bus24.out_valid) lat = i;
    end
    checkOutput("t1_out_latency", 32'(lat), 3);

    // Backpressure: result and stall must hold for ten cycles.
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus24.out_valid || bus24.acc_out != 24'd260170 || bus24.in_ready || !bus18.out_valid) bad++;
    end
    checkOutput("t3_hold_stable", 32'(bad), 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t3_out_valid_cleared", 32'(bus24.out_valid), 0);
    checkOutput("t3_acc_out_cleared", 32'(bus24.acc_out), 0);
    checkOutput("t3_in_ready_back", 32'(bus24.in_ready), 1);
    checkOutput("t3_queue_drained", 32'(q24.size()), 0);
    @(posedge clk);
    #1;

    // Signed and unsigned interpretations of the same operands.
    pushExp(24'd32506, 1'b0, 24'd32506, 1'b0);
    applyStimulus(1'b1, 8'd1, {8'h02, 8'h7F, 8'h80, 8'hFF}, {8'hFD, 8'h7F, 8'h80, 8'h01});
    waitIdle();
    pushExp(24'd33274, 1'b0, 24'd33274, 1'b0);
    applyStimulus(1'b0, 8'd1, {8'h02, 8'h7F, 8'h80, 8'hFF}, {8'hFD, 8'h7F, 8'h80, 8'h01});
    waitIdle();

    // clr after one of three beats: nothing may come out.
    applyStimulus(1'b0, 8'd3, 32'h0101_0101, 32'h0101_0101);
    clr = 1'b1;
    @(negedge clk);
    checkOutput("t4_in_ready_during_clr", 32'(bus24.in_ready), 0);
    @(posedge clk);
    #1 clr = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus24.out_valid || bus18.out_valid) n++;
    end
    checkOutput("t4_no_out_after_clr", 32'(n), 0);
    @(posedge clk);
    #1;
    pushExp(24'd4, 1'b0, 24'd4, 1'b0);
    applyStimulus(1'b0, 8'd0, 32'h0101_0101, 32'h0101_0101);
    waitIdle();

    // Overflow behaviour of the 18-bit instance, unsigned then signed.
`ifdef MAC_VEC_SATURATE_EN
    pushExp(24'd520200, 1'b0, 24'd262143, 1'b1);
`else
    pushExp(24'd520200, 1'b0, 24'd258056, 1'b0);
`endif
    applyStimulus(1'b0, 8'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 8'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitIdle();
`ifdef MAC_VEC_SATURATE_EN
    pushExp(24'd131072, 1'b0, 24'd131071, 1'b1);
`else
    pushExp(24'd131072, 1'b0, 24'd131072, 1'b0);
`endif
    applyStimulus(1'b1, 8'd2, 32'h8080_8080, 32'h8080_8080);
    applyStimulus(1'b1, 8'd2, 32'h8080_8080, 32'h8080_8080);
    waitIdle();

    // rst while a result is waiting in OUT.
    out_ready = 1'b0;
    applyStimulus(1'b0, 8'd1, 32'h0505_0505, 32'h0505_0505);
    n = 0;
    while (!bus24.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6_reached_out", 32'(bus24.out_valid), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_out_valid_after_rst", 32'(bus24.out_valid), 0);
    checkOutput("t6_acc_out_after_rst", 32'(bus24.acc_out), 0);
    checkOutput("t6_in_ready_after_rst", 32'(bus24.in_ready), 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    pushExp(24'd24, 1'b0, 24'd24, 1'b0);
    applyStimulus(1'b0, 8'd1, 32'h0202_0202, 32'h0303_0303);
    waitIdle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
